// File: rtl/fc_neuron_mac_if.sv
// Handshake/data bundle for fc_neuron_mac.
//   in_valid/in_ready   : request handshake carrying pixels, weights and bias
//   pixels/weights      : N_INPUTS packed elements, element i at [i*DATA_W +: DATA_W]
//   bias                : two's-complement accumulator preload
//   out_valid/out_ready : result handshake carrying result and sat
// The master modport is the producer/consumer side; the slave modport is the neuron.
interface fc_neuron_mac_if #(
  parameter int unsigned N_INPUTS = 8,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ACC_W    = 24
);
  logic                         in_valid;
  logic                         in_ready;
  logic [N_INPUTS*DATA_W-1:0]   pixels;
  logic [N_INPUTS*DATA_W-1:0]   weights;
  logic [ACC_W-1:0]             bias;
  logic                         out_valid;
  logic                         out_ready;
  logic [DATA_W-1:0]            result;
  logic                         sat;

  modport master (
    output in_valid, pixels, weights, bias, out_ready,
    input  in_ready, out_valid, result, sat
  );

  modport slave (
    input  in_valid, pixels, weights, bias, out_ready,
    output in_ready, out_valid, result, sat
  );
endinterface

// File: rtl/fc_neuron_mac.sv
// Sequential fully-connected neuron: one multiply-accumulate per cycle over N_INPUTS
// unsigned pixels and signed weights, bias preload, arithmetic shift, then clamp
// (ReLU to unsigned or signed saturation).
// Ports:
//   clk    : clock, rising edge
//   rst    : asynchronous active-high reset
//   mac_io : fc_neuron_mac_if.slave (in_valid/in_ready/pixels/weights/bias,
//            out_valid/out_ready/result/sat); its parameters must match this module's.
module fc_neuron_mac #(
  parameter int unsigned N_INPUTS = 8,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ACC_W    = 24,
  parameter int unsigned SHIFT    = 0,
  parameter int unsigned RELU_EN  = 1
) (
  input  logic           clk,
  input  logic           rst,
  fc_neuron_mac_if.slave mac_io
);

  // Index runs 0..N_INPUTS; the value N_INPUTS marks the finalisation cycle.
  localparam int unsigned IdxW = $clog2(N_INPUTS + 1);
  localparam int unsigned ProdW = 2 * DATA_W + 1;

  localparam logic signed [ACC_W-1:0] UMax = {{(ACC_W-DATA_W){1'b0}}, {DATA_W{1'b1}}};
  localparam logic signed [ACC_W-1:0] SMax = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SMin = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  if (N_INPUTS < 2) begin : g_chk_n
    $error("fc_neuron_mac: N_INPUTS must be >= 2");
  end
  if (DATA_W < 2) begin : g_chk_dw
    $error("fc_neuron_mac: DATA_W must be >= 2");
  end
  if (ACC_W < 2 * DATA_W + 2 + $clog2(N_INPUTS)) begin : g_chk_acc
    $error("fc_neuron_mac: ACC_W too narrow for worst-case accumulation");
  end
  if (SHIFT >= ACC_W) begin : g_chk_shift
    $error("fc_neuron_mac: SHIFT must be below ACC_W");
  end

  typedef enum logic [1:0] {StIdle, StAccum, StOutput} state_e;

  state_e                      state_q;
  logic [N_INPUTS*DATA_W-1:0]  pix_q;
  logic [N_INPUTS*DATA_W-1:0]  wgt_q;
  logic signed [ACC_W-1:0]     acc_q;
  logic [IdxW-1:0]             idx_q;
  logic [DATA_W-1:0]           result_q;
  logic                        sat_q;

  logic [DATA_W-1:0]           pix_sel;
  logic [DATA_W-1:0]           wgt_sel;
  logic signed [ProdW-1:0]     prod;
  logic signed [ACC_W-1:0]     prod_ext;
  logic signed [ACC_W-1:0]     shifted;
  logic [DATA_W-1:0]           result_d;
  logic                        sat_d;

  // Element mux for the current index.
  always_comb begin
    pix_sel = '0;
    wgt_sel = '0;
    for (int unsigned i = 0; i < N_INPUTS; i++) begin
      if (idx_q == IdxW'(i)) begin
        pix_sel = pix_q[i*DATA_W +: DATA_W];
        wgt_sel = wgt_q[i*DATA_W +: DATA_W];
      end
    end
  end

  // Pixel gets a zero sign bit so the multiply stays signed.
  always_comb begin
    prod     = $signed({1'b0, pix_sel}) * $signed(wgt_sel);
    prod_ext = {{(ACC_W-ProdW){prod[ProdW-1]}}, prod};
  end

  always_comb begin
    shifted  = acc_q >>> SHIFT;
    result_d = shifted[DATA_W-1:0];
    sat_d    = 1'b0;
    if (RELU_EN != 0) begin
      if (shifted < 0) begin
        result_d = '0;
      end else if (shifted > UMax) begin
        result_d = '1;
        sat_d    = 1'b1;
      end
    end else begin
      if (shifted < SMin) begin
        result_d = SMin[DATA_W-1:0];
        sat_d    = 1'b1;
      end else if (shifted > SMax) begin
        result_d = SMax[DATA_W-1:0];
        sat_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      pix_q    <= '0;
      wgt_q    <= '0;
      acc_q    <= '0;
      idx_q    <= '0;
      result_q <= '0;
      sat_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (mac_io.in_valid) begin
            pix_q   <= mac_io.pixels;
            wgt_q   <= mac_io.weights;
            acc_q   <= mac_io.bias;
            idx_q   <= '0;
            state_q <= StAccum;
          end
        end
        StAccum: begin
          // One extra cycle after the last add registers the clamped result.
          if (idx_q == IdxW'(N_INPUTS)) begin
            result_q <= result_d;
            sat_q    <= sat_d;
            state_q  <= StOutput;
          end else begin
            acc_q <= acc_q + prod_ext;
            idx_q <= idx_q + IdxW'(1);
          end
        end
        StOutput: begin
          if (mac_io.out_ready) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign mac_io.in_ready  = (state_q == StIdle) && !rst;
  assign mac_io.out_valid = (state_q == StOutput);
  assign mac_io.result    = result_q;
  assign mac_io.sat       = sat_q;

endmodule

// File: tb/tb_fc_neuron_mac.sv
// Directed bench for fc_neuron_mac: three instances (ReLU, signed, ReLU with SHIFT=4)
// driven with identical stimulus, checked against hand-computed values.
module tb_fc_neuron_mac;
  localparam int unsigned N  = 8;
  localparam int unsigned DW = 8;
  localparam int unsigned AW = 24;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fc_neuron_mac_if #(.N_INPUTS(N), .DATA_W(DW), .ACC_W(AW)) bus_relu ();
  fc_neuron_mac_if #(.N_INPUTS(N), .DATA_W(DW), .ACC_W(AW)) bus_sgn ();
  fc_neuron_mac_if #(.N_INPUTS(N), .DATA_W(DW), .ACC_W(AW)) bus_shf ();

  fc_neuron_mac #(.N_INPUTS(N), .DATA_W(DW), .ACC_W(AW), .SHIFT(0), .RELU_EN(1)) u_relu (
    .clk(clk), .rst(rst), .mac_io(bus_relu)
  );
  fc_neuron_mac #(.N_INPUTS(N), .DATA_W(DW), .ACC_W(AW), .SHIFT(0), .RELU_EN(0)) u_sgn (
    .clk(clk), .rst(rst), .mac_io(bus_sgn)
  );
  fc_neuron_mac #(.N_INPUTS(N), .DATA_W(DW), .ACC_W(AW), .SHIFT(4), .RELU_EN(1)) u_shf (
    .clk(clk), .rst(rst), .mac_io(bus_shf)
  );

  int n_checks = 0;
  int n_fails  = 0;
  int lat;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [7:0] p, input logic [7:0] w,
                       input logic [23:0] b);
    bus_relu.in_valid = iv; bus_relu.pixels = {N{p}}; bus_relu.weights = {N{w}};
    bus_relu.bias = b;
    bus_sgn.in_valid  = iv; bus_sgn.pixels  = {N{p}}; bus_sgn.weights  = {N{w}};
    bus_sgn.bias  = b;
    bus_shf.in_valid  = iv; bus_shf.pixels  = {N{p}}; bus_shf.weights  = {N{w}};
    bus_shf.bias  = b;
  endtask

  task automatic set_out_ready(input logic r);
    bus_relu.out_ready = r;
    bus_sgn.out_ready  = r;
    bus_shf.out_ready  = r;
  endtask

  // Accept one transaction, scramble inputs afterwards, wait (bounded) for out_valid.
  task automatic run_txn(input logic [7:0] p, input logic [7:0] w, input logic [23:0] b,
                         output int cycles);
    drive(1'b1, p, w, b);
    check_val("in_ready_before_accept", bus_relu.in_ready, 1);
    @(posedge clk); #1;
    drive(1'b0, 8'hAA, 8'h55, 24'h123456);
    cycles = 0;
    while (!bus_relu.out_valid && cycles < 50) begin
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  task automatic finish_txn();
    set_out_ready(1'b1);
    @(posedge clk); #1;
    set_out_ready(1'b0);
    check_val("out_valid_drop", bus_relu.out_valid, 0);
    check_val("in_ready_back", bus_relu.in_ready, 1);
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 8'd0, 8'd0, 24'd0);
    set_out_ready(1'b0);
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_out_valid", bus_relu.out_valid, 0);
    check_val("rst_result", bus_relu.result, 0);
    check_val("rst_sat", bus_relu.sat, 0);
    check_val("rst_in_ready", bus_relu.in_ready, 0);
    rst = 1'b0;
    #1;
    check_val("post_rst_in_ready", bus_relu.in_ready, 1);

    // All ones: 8 products of 1.
    run_txn(8'd1, 8'd1, 24'd0, lat);
    check_val("ones_latency", lat, 9);
    check_val("ones_relu_result", bus_relu.result, 8);
    check_val("ones_relu_sat", bus_relu.sat, 0);
    check_val("ones_sgn_result", bus_sgn.result, 8);
    check_val("ones_shf_result", bus_shf.result, 0);

    // Back-pressure: result must hold and a second request must be ignored.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 8'hFF, 8'h7F, 24'd0);
      @(posedge clk); #1;
      check_val("hold_out_valid", bus_relu.out_valid, 1);
      check_val("hold_result", bus_relu.result, 8);
      check_val("hold_in_ready", bus_relu.in_ready, 0);
    end
    drive(1'b0, 8'd0, 8'd0, 24'd0);
    finish_txn();
    @(posedge clk); #1;
    check_val("no_ghost_accept", bus_relu.out_valid, 0);
    check_val("no_ghost_in_ready", bus_relu.in_ready, 1);

    // 255 * 127 * 8 = 259080.
    run_txn(8'd255, 8'd127, 24'd0, lat);
    check_val("max_latency", lat, 9);
    check_val("max_relu_result", bus_relu.result, 8'hFF);
    check_val("max_relu_sat", bus_relu.sat, 1);
    check_val("max_sgn_result", bus_sgn.result, 8'h7F);
    check_val("max_sgn_sat", bus_sgn.sat, 1);
    check_val("max_shf_result", bus_shf.result, 8'hFF);
    check_val("max_shf_sat", bus_shf.sat, 1);
    finish_txn();

    // 10 * -1 * 8 = -80.
    run_txn(8'd10, 8'hFF, 24'd0, lat);
    check_val("neg_relu_result", bus_relu.result, 0);
    check_val("neg_relu_sat", bus_relu.sat, 0);
    check_val("neg_sgn_result", bus_sgn.result, 8'hB0);
    check_val("neg_sgn_sat", bus_sgn.sat, 0);
    check_val("neg_shf_result", bus_shf.result, 0);
    check_val("neg_shf_sat", bus_shf.sat, 0);
    finish_txn();

    // 16 * 16 * 8 - 48 = 2000; >>4 = 125.
    run_txn(8'd16, 8'd16, 24'hFFFFD0, lat);
    check_val("shift_shf_result", bus_shf.result, 125);
    check_val("shift_shf_sat", bus_shf.sat, 0);
    check_val("shift_relu_result", bus_relu.result, 8'hFF);
    check_val("shift_relu_sat", bus_relu.sat, 1);
    check_val("shift_sgn_result", bus_sgn.result, 8'h7F);
    check_val("shift_sgn_sat", bus_sgn.sat, 1);
    finish_txn();

    // Reset during the 4th accumulate cycle.
    drive(1'b1, 8'd1, 8'd1, 24'd0);
    @(posedge clk); #1;
    drive(1'b0, 8'd0, 8'd0, 24'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_val("midrst_out_valid", bus_relu.out_valid, 0);
    check_val("midrst_relu_result", bus_relu.result, 0);
    check_val("midrst_relu_sat", bus_relu.sat, 0);
    check_val("midrst_shf_result", bus_shf.result, 0);
    check_val("midrst_in_ready", bus_relu.in_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check_val("midrst_release_in_ready", bus_relu.in_ready, 1);

    // out_ready while idle must not produce anything.
    set_out_ready(1'b1);
    @(posedge clk); #1;
    set_out_ready(1'b0);
    check_val("idle_out_ready_no_effect", bus_relu.out_valid, 0);

    run_txn(8'd1, 8'd1, 24'd0, lat);
    check_val("after_rst_latency", lat, 9);
    check_val("after_rst_result", bus_relu.result, 8);
    check_val("after_rst_sat", bus_relu.sat, 0);
    finish_txn();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
